// File: rtl/pm_frame_scheduler_if.sv
// ============================================================================
// Module   : pm_frame_scheduler_if
// Brief    : Request/accept/done handshake between scheduler and frame generator.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pm_frame_scheduler_if #(
    parameter int CH_W = 2
);
    logic            gen_valid;
    logic [CH_W-1:0] gen_ch;
    logic            gen_ready;
    logic            gen_done;

    modport master (
        output gen_valid,
        output gen_ch,
        input  gen_ready,
        input  gen_done
    );

    modport slave (
        input  gen_valid,
        input  gen_ch,
        output gen_ready,
        output gen_done
    );
endinterface

`default_nettype wire

// File: rtl/pm_frame_scheduler.sv
// ============================================================================
// Module   : pm_frame_scheduler
// Brief    : Per-channel pacing credits with round-robin dispatch of one frame
//            at a time to a shared frame generator.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pm_frame_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int CREDIT_MAX = 7,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire  [NUM_CH-1:0]      pace_pulse,
    input  wire  [NUM_CH-1:0]      ch_en,
    pm_frame_scheduler_if.master   gen,
    output logic [NUM_CH-1:0]      credit_ovf,
    output logic                   busy
);

    localparam int                CRED_W        = $clog2(CREDIT_MAX + 1);
    localparam logic [CRED_W-1:0] C_CREDIT_FULL = CRED_W'(CREDIT_MAX);
    localparam logic [CRED_W-1:0] C_CREDIT_ONE  = CRED_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                          state_q;
    logic                            gen_valid_q;
    logic [CH_W-1:0]                 gen_ch_q;
    logic                            busy_q;
    logic [CH_W-1:0]                 last_grant_q;

    logic [NUM_CH-1:0][CRED_W-1:0]   credit_q;
    logic [NUM_CH-1:0][CRED_W-1:0]   credit_d;
    logic [NUM_CH-1:0]               credit_ovf_q;
    logic [NUM_CH-1:0]               credit_ovf_d;

    logic                            w_handshake;
    logic [NUM_CH-1:0]               w_consume;
    logic [NUM_CH-1:0]               w_eligible;
    logic                            w_found;
    logic [CH_W-1:0]                 w_winner;
    int                              w_idx;

    // gen_valid_q is only ever high in ISSUE, so it alone qualifies the accept.
    assign w_handshake = gen_valid_q && gen.gen_ready;

    always_comb begin
        w_consume  = '0;
        w_eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_consume[i]  = w_handshake && (gen_ch_q == CH_W'(i));
            w_eligible[i] = ch_en[i] && (credit_q[i] != '0);
        end
    end

    always_comb begin
        credit_d     = credit_q;
        credit_ovf_d = credit_ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i]) begin
                credit_d[i] = '0;
            end else if (pace_pulse[i] && !w_consume[i]) begin
                if (credit_q[i] == C_CREDIT_FULL) begin
                    credit_ovf_d[i] = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + C_CREDIT_ONE;
                end
            end else if (w_consume[i] && !pace_pulse[i] && (credit_q[i] != '0)) begin
                credit_d[i] = credit_q[i] - C_CREDIT_ONE;
            end
        end
    end

    // Search starts one past the last accepted channel and wraps ascending.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = (int'(last_grant_q) + k) % NUM_CH;
            if (!w_found && w_eligible[CH_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = CH_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q     <= '0;
            credit_ovf_q <= '0;
        end else begin
            credit_q     <= credit_d;
            credit_ovf_q <= credit_ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gen_valid_q  <= 1'b0;
            gen_ch_q     <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        gen_ch_q    <= w_winner;
                        gen_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                // Request is held unconditionally until accepted, even if disabled.
                S_ISSUE: begin
                    if (gen.gen_ready) begin
                        gen_valid_q  <= 1'b0;
                        last_grant_q <= gen_ch_q;
                        state_q      <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (gen.gen_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    gen_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign gen.gen_valid = gen_valid_q;
    assign gen.gen_ch    = gen_ch_q;
    assign credit_ovf    = credit_ovf_q;
    assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pm_frame_scheduler.sv
// ============================================================================
// Module   : tb_pm_frame_scheduler
// Brief    : Directed scoreboard bench for pm_frame_scheduler.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pm_frame_scheduler;

    localparam int NUM_CH     = 4;
    localparam int CREDIT_MAX = 7;
    localparam int CH_W       = 2;

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] pace_pulse;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] credit_ovf;
    logic              busy;

    pm_frame_scheduler_if #(.CH_W(CH_W)) gen_if ();

    pm_frame_scheduler #(
        .NUM_CH     (NUM_CH),
        .CREDIT_MAX (CREDIT_MAX),
        .CH_W       (CH_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pace_pulse (pace_pulse),
        .ch_en      (ch_en),
        .gen        (gen_if),
        .credit_ovf (credit_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int exp_q[$];
    bit auto_done;
    int done_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every accepted request must match the next expected channel.
    task automatic monitor();
        int e;
        forever begin
            @(negedge clk);
            if (rst_n && gen_if.gen_valid && gen_if.gen_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_grant: got ch %0d expected none", int'(gen_if.gen_ch));
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_ch", int'(gen_if.gen_ch), e);
                end
            end
        end
    endtask

    // Generator model: gen_done sampled two edges after each accept edge.
    task automatic generator();
        forever begin
            @(negedge clk);
            if (auto_done) begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    gen_if.gen_done = (done_cnt == 0);
                end else begin
                    gen_if.gen_done = 1'b0;
                end
                if (rst_n && gen_if.gen_valid && gen_if.gen_ready) done_cnt = 2;
            end
        end
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] m);
        pace_pulse = m;
        tick();
        pace_pulse = '0;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        pace_pulse       = '0;
        gen_if.gen_ready = 1'b0;
        gen_if.gen_done  = 1'b0;
        auto_done        = 1'b0;
        done_cnt         = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (busy || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_timeout: busy %0d pending %0d expected busy 0 pending 0",
                     name, int'(busy), exp_q.size());
            exp_q.delete();
        end
        repeat (10) tick();
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        auto_done        = 1'b0;
        done_cnt         = 0;
        rst_n            = 1'b0;
        pace_pulse       = '0;
        ch_en            = '0;
        gen_if.gen_ready = 1'b0;
        gen_if.gen_done  = 1'b0;

        fork
            monitor();
            generator();
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (2) tick();
        chk("rst_valid", int'(gen_if.gen_valid), 0);
        chk("rst_ch",    int'(gen_if.gen_ch), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_ovf",   int'(credit_ovf), 0);
        rst_n = 1'b1;
        tick();

        // Single pulse latency on channel 0
        ch_en            = 4'b0001;
        gen_if.gen_ready = 1'b1;
        auto_done        = 1'b1;
        tick();
        exp_q.push_back(0);
        pulse(4'b0001);
        chk("single_valid_t1", int'(gen_if.gen_valid), 0);
        tick();
        chk("single_valid_t2", int'(gen_if.gen_valid), 1);
        chk("single_ch",       int'(gen_if.gen_ch), 0);
        chk("single_busy",     int'(busy), 1);
        wait_idle("single", 50);
        chk("single_idle_valid", int'(gen_if.gen_valid), 0);
        chk("single_idle_busy",  int'(busy), 0);

        // Fairness: credit 3 on every channel
        do_reset();
        ch_en = 4'b1111;
        repeat (3) begin
            pulse(4'b1111);
            tick();
        end
        chk("fair_ovf", int'(credit_ovf), 0);
        chk("fair_first_ch", int'(gen_if.gen_ch), 0);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NUM_CH; c++) exp_q.push_back(c);
        end
        auto_done        = 1'b1;
        gen_if.gen_ready = 1'b1;
        wait_idle("fair", 300);
        chk("fair_busy", int'(busy), 0);

        // Saturation on channel 1
        do_reset();
        ch_en = 4'b0010;
        repeat (7) begin
            pulse(4'b0010);
            tick();
        end
        chk("sat_ovf_at_max", int'(credit_ovf), 0);
        repeat (2) begin
            pulse(4'b0010);
            tick();
        end
        chk("sat_ovf_set", int'(credit_ovf), 2);
        chk("sat_valid",   int'(gen_if.gen_valid), 1);
        chk("sat_ch",      int'(gen_if.gen_ch), 1);
        repeat (7) exp_q.push_back(1);
        auto_done        = 1'b1;
        gen_if.gen_ready = 1'b1;
        wait_idle("sat", 300);
        chk("sat_ovf_sticky", int'(credit_ovf), 2);
        ch_en = 4'b0000;
        repeat (2) tick();
        chk("sat_ovf_after_disable", int'(credit_ovf), 2);
        do_reset();
        chk("sat_ovf_after_reset", int'(credit_ovf), 0);

        // Pace pulse coincident with handshake on channel 2
        ch_en = 4'b0100;
        pulse(4'b0100);
        tick();
        chk("simul_valid", int'(gen_if.gen_valid), 1);
        chk("simul_ch",    int'(gen_if.gen_ch), 2);
        exp_q.push_back(2);
        exp_q.push_back(2);
        auto_done        = 1'b1;
        gen_if.gen_ready = 1'b1;
        pace_pulse       = 4'b0100;
        tick();
        pace_pulse       = '0;
        wait_idle("simul", 100);
        chk("simul_ovf",  int'(credit_ovf), 0);
        chk("simul_busy", int'(busy), 0);

        // Hold rule: request for channel 3 survives disable
        do_reset();
        ch_en = 4'b1000;
        pulse(4'b1000);
        tick();
        pulse(4'b1000);
        tick();
        exp_q.push_back(3);
        for (int c = 1; c <= 10; c++) begin
            if (c == 4) ch_en = 4'b0000;
            tick();
            chk("hold_valid", int'(gen_if.gen_valid), 1);
            chk("hold_ch",    int'(gen_if.gen_ch), 3);
        end
        auto_done        = 1'b1;
        gen_if.gen_ready = 1'b1;
        ch_en            = 4'b1000;
        wait_idle("hold", 100);
        chk("hold_idle_valid", int'(gen_if.gen_valid), 0);
        chk("hold_idle_busy",  int'(busy), 0);

        // Reset while waiting for gen_done
        do_reset();
        ch_en = 4'b0100;
        pulse(4'b0100);
        tick();
        pulse(4'b0100);
        tick();
        exp_q.push_back(2);
        gen_if.gen_ready = 1'b1;
        tick();
        gen_if.gen_ready = 1'b0;
        chk("mid_busy",  int'(busy), 1);
        chk("mid_valid", int'(gen_if.gen_valid), 0);
        chk("mid_ch",    int'(gen_if.gen_ch), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_valid", int'(gen_if.gen_valid), 0);
        chk("mid_rst_ch",    int'(gen_if.gen_ch), 0);
        chk("mid_rst_ovf",   int'(credit_ovf), 0);
        ch_en = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        gen_if.gen_done = 1'b1;
        tick();
        gen_if.gen_done = 1'b0;
        repeat (5) tick();
        chk("post_rst_busy",  int'(busy), 0);
        chk("post_rst_valid", int'(gen_if.gen_valid), 0);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
